// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_queue
//  Purpose  : Sequential instruction prefetcher with DEPTH-entry queue,
//             valid/ready decoder interface, redirect flush and done flag.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] prog_len,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_count;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_infl_pc;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic              r_out_valid;
    logic              r_done;

    logic [DATA_W-1:0] r_instr_q [DEPTH];
    logic [ADDR_W-1:0] r_pc_q    [DEPTH];

    logic [OCC_W-1:0]  w_occupancy;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_next;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_inflight_next;
    logic              w_done_next;

    // The in-flight word already owns a slot, so the queue can never overflow.
    assign w_occupancy = OCC_W'(r_count) + OCC_W'(r_inflight);
    assign w_issue     = rst_n & run & ~redirect & (r_pc < prog_len)
                       & (w_occupancy < OCC_W'(DEPTH));
    assign w_push      = r_inflight & ~redirect;
    assign w_pop       = r_out_valid & out_ready;

    always_comb begin
        w_count_next    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_pc_next       = w_issue ? r_pc + ADDR_W'(1) : r_pc;
        w_inflight_next = w_issue;
        if (redirect) begin
            w_count_next = '0;
            w_pc_next    = redirect_pc;
        end
        w_done_next = (w_pc_next >= prog_len) && (w_count_next == '0) && !w_inflight_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_count     <= '0;
            r_inflight  <= 1'b0;
            r_infl_pc   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_count     <= w_count_next;
            r_inflight  <= w_inflight_next;
            r_out_valid <= (w_count_next != '0);
            r_done      <= w_done_next;
            if (w_issue) begin
                r_infl_pc <= r_pc;
            end
            if (redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Payload storage needs no reset: entries are only visible through out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_q[r_wr_ptr] <= imem_rdata;
            r_pc_q[r_wr_ptr]    <= r_infl_pc;
        end
    end

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_valid ? r_instr_q[r_rd_ptr] : '0;
    assign out_pc    = r_out_valid ? r_pc_q[r_rd_ptr]    : '0;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_queue
//  Purpose  : Self-checking bench for instr_fetch_queue with directed and
//             randomized scenarios against a stream-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [4:0]  prog_len = '0;
    logic        imem_req;
    logic [4:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [4:0]  out_pc;
    logic        redirect = 1'b0;
    logic [4:0]  redirect_pc = '0;
    logic        done;

    logic [31:0] mem [32];
    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_queue #(.ADDR_W(5), .DATA_W(32), .DEPTH(4), .RESET_PC(5'd0)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .prog_len(prog_len),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .redirect(redirect), .redirect_pc(redirect_pc), .done(done)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous memory
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] plen);
        rst_n = 1'b0; run = 1'b0; out_ready = 1'b0; redirect = 1'b0;
        redirect_pc = '0; prog_len = plen;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; prog_len = 5'd4; out_ready = 1'b1; redirect = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_instr !== 32'd0 ||
            out_pc !== 5'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%0d done=%b, required all zero",
                     imem_req, out_valid, out_instr, out_pc, done);
        end
    endtask

    task automatic test_program();
        logic [4:0] e;
        do_reset(5'd4);
        for (int c = 0; c <= 6; c++) begin
            cyc(); run = 1'b1; out_ready = 1'b1; #1;
            if (c == 0) begin
                n_tests++;
                if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin
                    n_fail++;
                    $display("FAIL prog_first_req: req=%b addr=%0d, required 1/0", imem_req, imem_addr);
                end
            end
            if (c >= 2 && c <= 5) begin
                e = 5'(c - 2);
                n_tests++;
                if (out_valid !== 1'b1 || out_pc !== e || out_instr !== mem[e]) begin
                    n_fail++;
                    $display("FAIL prog_stream c%0d: valid=%b pc=%0d instr=%h, required 1/%0d/%h",
                             c, out_valid, out_pc, out_instr, e, mem[e]);
                end
            end else begin
                n_tests++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL prog_idle c%0d: valid=%b, required 0", c, out_valid);
                end
            end
            if (c == 6) begin
                n_tests++;
                if (done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL prog_done: done=%b, required 1", done);
                end
            end
        end
        run = 1'b0;
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        logic [4:0] exp_pc = '0;
        do_reset(5'd20);
        for (int c = 0; c <= 9; c++) begin
            cyc(); run = 1'b1; out_ready = 1'b0; #1;
            if (imem_req) nreq++;
            if (c >= 2) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_pc !== 5'd0 || out_instr !== mem[0]) begin
                    n_fail++;
                    $display("FAIL bp_head_stable c%0d: valid=%b pc=%0d instr=%h, required 1/0/%h",
                             c, out_valid, out_pc, out_instr, mem[0]);
                end
            end
        end
        n_tests++;
        if (nreq != 4 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_fill: requests=%0d req_now=%b, required 4/0", nreq, imem_req);
        end
        for (int c = 0; c < 60; c++) begin
            cyc(); out_ready = 1'b1; #1;
            if (out_valid === 1'b1) begin
                n_tests++;
                if (out_pc !== exp_pc || out_instr !== mem[exp_pc]) begin
                    n_fail++;
                    $display("FAIL bp_drain: pc=%0d instr=%h, required %0d/%h",
                             out_pc, out_instr, exp_pc, mem[exp_pc]);
                end
                exp_pc++;
            end
            if (done === 1'b1) break;
        end
        n_tests++;
        if (exp_pc !== 5'd20 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_complete: popped_to=%0d done=%b, required 20/1", exp_pc, done);
        end
    endtask

    task automatic test_redirect();
        logic [4:0] exp_pc = 5'd20;
        do_reset(5'd31);
        cyc(); redirect = 1'b1; redirect_pc = 5'd5; #1;
        for (int c = 0; c <= 3; c++) begin
            cyc(); redirect = 1'b0; run = 1'b1; out_ready = 1'b0; #1;
            n_tests++;
            if (imem_req !== 1'b1 || imem_addr !== 5'(5 + c)) begin
                n_fail++;
                $display("FAIL redir_fill c%0d: req=%b addr=%0d, required 1/%0d", c, imem_req, imem_addr, 5 + c);
            end
        end
        cyc(); #1;
        n_tests++;
        if (imem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 5'd5) begin
            n_fail++;
            $display("FAIL redir_pre: req=%b valid=%b pc=%0d, required 0/1/5", imem_req, out_valid, out_pc);
        end
        redirect = 1'b1; redirect_pc = 5'd20;
        for (int c = 5; c <= 6; c++) begin
            cyc(); redirect = 1'b0; out_ready = 1'b1; #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL redir_flush c%0d: valid=%b pc=%0d, required valid 0", c, out_valid, out_pc);
            end
        end
        for (int c = 7; c <= 16; c++) begin
            cyc(); #1;
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem[exp_pc]) begin
                n_fail++;
                $display("FAIL redir_stream c%0d: valid=%b pc=%0d instr=%h, required 1/%0d/%h",
                         c, out_valid, out_pc, out_instr, exp_pc, mem[exp_pc]);
            end
            exp_pc++;
        end
        run = 1'b0;
    endtask

    task automatic test_redirect_pop();
        do_reset(5'd31);
        for (int c = 0; c <= 4; c++) begin
            cyc(); run = 1'b1; out_ready = 1'b1; #1;
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 5'd2) begin
            n_fail++;
            $display("FAIL rpop_head: valid=%b pc=%0d, required 1/2", out_valid, out_pc);
        end
        redirect = 1'b1; redirect_pc = 5'd10;
        cyc(); redirect = 1'b0; #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rpop_empty: valid=%b pc=%0d, required valid 0", out_valid, out_pc);
        end
        cyc(); cyc(); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 5'd10) begin
            n_fail++;
            $display("FAIL rpop_restart: valid=%b pc=%0d, required 1/10", out_valid, out_pc);
        end
        run = 1'b0;
    endtask

    task automatic test_done();
        int nreq = 0;
        do_reset(5'd0);
        cyc(); run = 1'b1; #1;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_len0: done=%b, required 1", done);
        end
        for (int c = 0; c < 5; c++) begin
            if (imem_req) nreq++;
            cyc(); #1;
        end
        do_reset(5'd25);
        cyc(); redirect = 1'b1; redirect_pc = 5'd31; #1;
        cyc(); redirect = 1'b0; run = 1'b1; #1;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_redir_past_end: done=%b, required 1", done);
        end
        for (int c = 0; c < 5; c++) begin
            if (imem_req) nreq++;
            cyc(); #1;
        end
        n_tests++;
        if (nreq != 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_no_fetch: requests=%0d done=%b, required 0/1", nreq, done);
        end
        run = 1'b0;
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        do_reset(5'd31);
        for (int c = 0; c <= 4; c++) begin
            cyc(); run = 1'b1; out_ready = 1'b1; #1;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_pc !== 5'd0 || out_instr !== 32'd0 ||
            done !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: valid=%b pc=%0d instr=%h done=%b req=%b, required all zero",
                     out_valid, out_pc, out_instr, done, imem_req);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL async_restart_req: req=%b addr=%0d, required 1/0", imem_req, imem_addr);
        end
        for (int c = 0; c < 6 && !seen; c++) begin
            cyc(); #1;
            if (out_valid === 1'b1) begin
                seen = 1;
                n_tests++;
                if (out_pc !== 5'd0 || out_instr !== mem[0]) begin
                    n_fail++;
                    $display("FAIL async_first_pop: pc=%0d instr=%h, required 0/%h", out_pc, out_instr, mem[0]);
                end
            end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL async_first_pop: no output within 6 cycles, required pc 0");
        end
        run = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0] plen, exp_pc, hold_pc, target;
        logic [31:0] hold_instr;
        bit hold = 0;
        plen = 5'($urandom_range(8, 31));
        do_reset(plen);
        exp_pc = 5'd0;
        for (int c = 0; c < 1500; c++) begin
            cyc();
            run         = ($urandom_range(0, 9) != 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = 5'($urandom_range(0, 31));
            #1;
            if (hold) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_pc !== hold_pc || out_instr !== hold_instr) begin
                    n_fail++;
                    $display("FAIL rnd_hold c%0d: valid=%b pc=%0d, required 1/%0d", c, out_valid, out_pc, hold_pc);
                end
            end
            if (out_valid === 1'b1 && done === 1'b1) begin
                n_tests++; n_fail++;
                $display("FAIL rnd_done_early c%0d: done=1 with valid=1, required done 0", c);
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_tests++;
                if (out_pc !== exp_pc || out_instr !== mem[exp_pc]) begin
                    n_fail++;
                    $display("FAIL rnd_pop c%0d: pc=%0d instr=%h, required %0d/%h",
                             c, out_pc, out_instr, exp_pc, mem[exp_pc]);
                end
                exp_pc++;
            end
            hold       = out_valid && !out_ready && !redirect;
            hold_pc    = out_pc;
            hold_instr = out_instr;
            if (redirect) exp_pc = redirect_pc;
        end
        target = (exp_pc < plen) ? plen : exp_pc;
        for (int c = 0; c < 100; c++) begin
            cyc(); redirect = 1'b0; run = 1'b1; out_ready = 1'b1; #1;
            if (out_valid === 1'b1) begin
                n_tests++;
                if (out_pc !== exp_pc || out_instr !== mem[exp_pc]) begin
                    n_fail++;
                    $display("FAIL rnd_drain: pc=%0d instr=%h, required %0d/%h",
                             out_pc, out_instr, exp_pc, mem[exp_pc]);
                end
                exp_pc++;
            end
            if (done === 1'b1) break;
        end
        n_tests++;
        if (done !== 1'b1 || exp_pc !== target) begin
            n_fail++;
            $display("FAIL rnd_final: done=%b popped_to=%0d, required 1/%0d", done, exp_pc, target);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        test_reset();
        test_program();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_done();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
